// File: rtl/eth_crc_pkg.sv
// rtl/eth_crc_pkg.sv - CRC-32 constants, FCS checker states and bit-order helpers
package eth_crc_pkg;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // s_bytes on an eop beat: 00 means all four bytes valid, otherwise the count of low bytes
  localparam logic [1:0] SB_FULL = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    TAIL  = 2'd2,
    DONE  = 2'd3
  } fcs_state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/CRC32_D32.sv
// rtl/CRC32_D32.sv - CRC-32 next-state for a 32-bit data word, data[31] shifted in first
module CRC32_D32
  import eth_crc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc;
    for (int i = 31; i >= 0; i--) begin
      crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - CRC-32 next-state for one data byte, data[7] shifted in first
module crc32_d8
  import eth_crc_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc;
    for (int i = 7; i >= 0; i--) begin
      crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/eth_rx_fcs_checker.sv
// rtl/eth_rx_fcs_checker.sv - RX FCS residue check with length, runt and oversize status per frame
module eth_rx_fcs_checker
  import eth_crc_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_sop,
  input  logic             s_eop,
  input  logic [1:0]       s_bytes,
  output logic             st_valid,
  output logic             st_fcs_ok,
  output logic             st_runt,
  output logic             st_oversize,
  output logic [LEN_W-1:0] st_len,
  output logic             drop_pulse
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);

  fcs_state_e       state, state_n;
  logic [31:0]      crc, crc_n, crc_base, crc_word, crc_byte;
  logic [31:0]      tail_word, tail_word_n, word_rev;
  logic [7:0]       byte_rev;
  logic [1:0]       tail_left, tail_left_n;
  logic [LEN_W-1:0] len, len_n, len_base;
  logic             accept, fin, drop;

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [2:0] inc);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-2){1'b0}}, inc};
    return s[LEN_W] ? {LEN_W{1'b1}} : s[LEN_W-1:0];
  endfunction

  assign s_ready  = !reset && (state == IDLE || state == FRAME);
  assign accept   = s_valid && s_ready;
  // A sop beat always restarts from a fresh CRC, even when it abandons a frame in progress
  assign crc_base = s_sop ? CRC_INIT : crc;
  assign len_base = s_sop ? '0 : len;
  assign word_rev = bitrev32(s_data);
  assign byte_rev = bitrev8(tail_word[7:0]);

  CRC32_D32 u_crc_word (.crc(crc_base), .data(word_rev), .crc_out(crc_word));
  crc32_d8  u_crc_byte (.crc(crc),      .data(byte_rev), .crc_out(crc_byte));

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    len_n       = len;
    tail_word_n = tail_word;
    tail_left_n = tail_left;
    fin         = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE, FRAME: begin
        if (accept) begin
          if ((state == IDLE && !s_sop) || (state == FRAME && s_sop)) drop = 1'b1;
          if (state == FRAME || s_sop) begin
            if (s_eop && s_bytes != SB_FULL) begin
              crc_n       = crc_base;
              len_n       = len_base;
              tail_word_n = s_data;
              tail_left_n = s_bytes;
              state_n     = TAIL;
            end else begin
              crc_n   = crc_word;
              len_n   = sat_add(len_base, 3'd4);
              state_n = s_eop ? DONE : FRAME;
              fin     = s_eop;
            end
          end
        end
      end
      TAIL: begin
        crc_n       = crc_byte;
        len_n       = sat_add(len, 3'd1);
        tail_word_n = {8'h00, tail_word[31:8]};
        tail_left_n = tail_left - 2'd1;
        if (tail_left == 2'd1) begin
          state_n = DONE;
          fin     = 1'b1;
        end
      end
      DONE: begin
        crc_n   = CRC_INIT;
        len_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      crc         <= CRC_INIT;
      len         <= '0;
      tail_word   <= '0;
      tail_left   <= '0;
      st_valid    <= 1'b0;
      st_fcs_ok   <= 1'b0;
      st_runt     <= 1'b0;
      st_oversize <= 1'b0;
      st_len      <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      crc        <= crc_n;
      len        <= len_n;
      tail_word  <= tail_word_n;
      tail_left  <= tail_left_n;
      st_valid   <= fin;
      drop_pulse <= drop;
      // Status is captured as the frame enters DONE so it is valid alongside st_valid
      if (fin) begin
        st_fcs_ok   <= (crc_n == CRC_RESIDUE);
        st_len      <= len_n;
        st_runt     <= (len_n < MIN_LEN);
        st_oversize <= (len_n > MAX_LEN);
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_checker.sv
// tb/tb_eth_rx_fcs_checker.sv - randomized self-checking bench for eth_rx_fcs_checker
module tb_eth_rx_fcs_checker;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          due;
    logic [15:0] len;
    logic        ok;
    logic        runt;
    logic        over;
  } st_t;

  localparam logic [31:0] RESIDUE_REFL = 32'hDEBB20E3;

  logic        clk, reset, s_valid, s_ready, s_sop, s_eop;
  logic [31:0] s_data;
  logic [1:0]  s_bytes;
  logic        st_valid, st_fcs_ok, st_runt, st_oversize, drop_pulse;
  logic [15:0] st_len;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  eth_rx_fcs_checker dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sop(s_sop), .s_eop(s_eop), .s_bytes(s_bytes), .st_valid(st_valid),
    .st_fcs_ok(st_fcs_ok), .st_runt(st_runt), .st_oversize(st_oversize),
    .st_len(st_len), .drop_pulse(drop_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reflected byte-wise CRC-32 without final inversion
  function automatic logic [31:0] crc_refl(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input int plen, input bit corrupt);
    bq_t q;
    logic [31:0] f;
    int pos;
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    f = ~crc_refl(q);
    for (int i = 0; i < 4; i++) q.push_back(f[8*i +: 8]);
    if (corrupt) begin
      pos = $urandom_range(q.size() - 1, 0);
      q[pos] = q[pos] ^ (8'h01 << $urandom_range(7, 0));
    end
    return q;
  endfunction

  // ---------------- reference model and per-cycle compare ----------------
  st_t         pend[$];
  st_t         e, got;
  bq_t         fbytes;
  bit          in_frame = 0;
  int          drop_due = -1;
  int          busy_until = -1;
  int          nb;
  logic        exp_ready, exp_st;
  logic [15:0] held_len = 0;
  logic        held_ok = 0, held_runt = 0, held_over = 0;
  int          st_count = 0, drop_count = 0, last_st_cyc = -1;
  logic [15:0] last_len;
  logic        last_ok, last_runt, last_over;

  always @(negedge clk) begin
    if (st_valid) begin
      st_count++;
      last_st_cyc = cyc;
      last_len = st_len; last_ok = st_fcs_ok; last_runt = st_runt; last_over = st_oversize;
    end
    if (drop_pulse) drop_count++;
    if (reset) begin
      pend.delete(); fbytes.delete(); in_frame = 0; drop_due = -1; busy_until = -1;
      held_len = 0; held_ok = 0; held_runt = 0; held_over = 0;
      chk("reset_s_ready", s_ready, 0);
      chk("reset_st_valid", st_valid, 0);
      chk("reset_drop", drop_pulse, 0);
    end else begin
      exp_ready = (cyc > busy_until);
      chk("s_ready", s_ready, exp_ready);
      chk("drop_pulse", drop_pulse, drop_due == cyc);
      exp_st = (pend.size() > 0) && (pend[0].due == cyc);
      chk("st_valid", st_valid, exp_st);
      if (exp_st) begin
        got = pend.pop_front();
        held_len = got.len; held_ok = got.ok; held_runt = got.runt; held_over = got.over;
      end
      chk("st_len", st_len, held_len);
      chk("st_fcs_ok", st_fcs_ok, held_ok);
      chk("st_runt", st_runt, held_runt);
      chk("st_oversize", st_oversize, held_over);
      if (s_valid && exp_ready) begin
        if (!in_frame && !s_sop) drop_due = cyc + 1;
        else begin
          if (s_sop) begin
            if (in_frame) drop_due = cyc + 1;
            fbytes.delete();
            in_frame = 1;
          end
          nb = (s_eop && s_bytes != 2'b00) ? int'(s_bytes) : 4;
          for (int i = 0; i < nb; i++) fbytes.push_back(s_data[8*i +: 8]);
          if (s_eop) begin
            e.due  = cyc + ((s_bytes == 2'b00) ? 1 : int'(s_bytes) + 1);
            e.len  = (fbytes.size() > 65535) ? 16'hFFFF : 16'(fbytes.size());
            e.ok   = (crc_refl(fbytes) == RESIDUE_REFL);
            e.runt = (e.len < 16'd64);
            e.over = (e.len > 16'd1518);
            pend.push_back(e);
            busy_until = e.due;
            in_frame = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [1:0] nbytes, output int acc);
    bit ok;
    int guard;
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_bytes = nbytes;
    ok = 0; guard = 0; acc = -1;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = s_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = $urandom;
  endtask

  task automatic send_bytes(input bq_t q, input bit with_eop, input int gap_max,
                            output int first_acc, output int eop_acc);
    int n, nbeats, acc;
    bit last;
    logic [31:0] w;
    n = q.size();
    nbeats = (n + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      w = $urandom;
      for (int i = 0; i < 4; i++) if (4*b + i < n) w[8*i +: 8] = q[4*b + i];
      step($urandom_range(gap_max, 0));
      last = with_eop && (b == nbeats - 1);
      send_beat(w, b == 0, last, last ? 2'(n % 4) : 2'b00, acc);
      if (b == 0) first_acc = acc;
      if (last) eop_acc = acc;
    end
  endtask

  bq_t q, q2;
  int  fa, ea, fa2, ea2, sc, dc;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_sop = 1'b0; s_eop = 1'b0; s_bytes = 2'b00;
    step(3);
    chk("reset_st_len", st_len, 0);
    chk("reset_st_fcs_ok", st_fcs_ok, 0);
    chk("reset_st_runt", st_runt, 0);
    chk("reset_st_oversize", st_oversize, 0);
    reset = 1'b0;
    step(2);

    // check value of the standard CRC-32 pins the bench model
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    chk("model_check_value", ~crc_refl(q), 32'hCBF43926);
    q = make_frame(0, 0);
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);

    // 1: "123456789" + FCS, one tail byte
    send_bytes(q, 1, 0, fa, ea);
    step(5);
    chk("t1_latency", last_st_cyc - ea, 2);
    chk("t1_len", last_len, 13);
    chk("t1_ok", last_ok, 1);
    chk("t1_runt", last_runt, 1);
    chk("t1_oversize", last_over, 0);

    // 2: bit 5 of beat 2 flipped
    q[8] = q[8] ^ 8'h20;
    send_bytes(q, 1, 1, fa, ea);
    step(5);
    chk("t2_ok", last_ok, 0);
    chk("t2_len", last_len, 13);

    // 3: minimum-size and just-oversize frames
    send_bytes(make_frame(60, 0), 1, 1, fa, ea);
    step(5);
    chk("t3_len64", last_len, 64);
    chk("t3_runt64", last_runt, 0);
    chk("t3_ok64", last_ok, 1);
    send_bytes(make_frame(1515, 0), 1, 0, fa, ea);
    step(5);
    chk("t3_len1519", last_len, 1519);
    chk("t3_over1519", last_over, 1);
    chk("t3_ok1519", last_ok, 1);

    // 4: three tail bytes with valid held high, then back-to-back full-word frames
    send_bytes(make_frame(63, 0), 1, 0, fa, ea);
    send_bytes(make_frame(60, 0), 1, 0, fa2, ea2);
    chk("t4_tail_stall", fa2 - ea, 5);
    send_bytes(make_frame(60, 0), 1, 0, fa, ea);
    chk("t4_b2b_gap", fa - ea2, 2);
    step(5);
    chk("t4_len", last_len, 64);
    chk("t4_ok", last_ok, 1);

    // 5: stray beat in idle, then a frame restarted by sop
    dc = drop_count;
    send_beat($urandom, 0, 0, 2'b00, fa);
    step(2);
    chk("t5_idle_drop", drop_count - dc, 1);
    send_bytes(make_frame(20, 0), 0, 0, fa, ea);
    send_bytes(make_frame(70, 0), 1, 1, fa, ea);
    step(5);
    chk("t5_drops", drop_count - dc, 2);
    chk("t5_len", last_len, 74);
    chk("t5_ok", last_ok, 1);

    // 6: reset during the second tail cycle
    sc = st_count;
    send_bytes(make_frame(63, 0), 1, 0, fa, ea);
    step(1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(6);
    chk("t6_no_status", st_count - sc, 0);
    chk("t6_ready", s_ready, 1);
    send_bytes(make_frame(61, 0), 1, 1, fa, ea);
    step(5);
    chk("t6_len", last_len, 65);
    chk("t6_ok", last_ok, 1);

    // randomized traffic checked cycle by cycle against the model
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(9, 0) == 0) send_beat($urandom, 0, $urandom_range(1, 0), 2'($urandom), fa);
      if ($urandom_range(9, 0) == 0) begin
        q2 = make_frame($urandom_range(12, 0), 0);
        send_bytes(q2, 0, 1, fa, ea);
      end
      if ($urandom_range(9, 0) == 0) begin
        q2.delete();
        for (int i = 0; i < int'($urandom_range(7, 1)); i++) q2.push_back(8'($urandom));
      end else begin
        q2 = make_frame($urandom_range(80, 0), $urandom_range(2, 0) == 0);
      end
      send_bytes(q2, 1, $urandom_range(2, 0), fa, ea);
    end
    step(8);
    chk("all_status_seen", pend.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
